mux4_rr_scheduler: RTL and testbench

Round-robin select sequencer sitting directly upstream of the structural 4:1 mux. It arbitrates among four channel request lines and drives the mux's 2-bit select. It waits a programmable settle time, samples the mux output and presents the sampled bit, tagged with its channel, on a valid/ready output port. This turns the combinational 4:1 mux into a fair, time-multiplexed serial channel scanner.

---
 rtl/mux_sched_pkg.sv | 18 +
 rtl/rr_pick4.sv | 34 +++
 rtl/mux4_rr_scheduler.sv | 108 ++++++++++
 tb/tb_mux4_rr_scheduler.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mux_sched_pkg.sv
// mux_sched_pkg
//   Shared constants and types for the round-robin mux select scheduler.
//   NUM_CH / CH_W : channel count and channel-index width.
//   CNT_W         : settle-counter width (holds SETTLE_CYC-1, SETTLE_CYC <= 15).
//   sched_state_e : scheduler FSM state encoding.
package mux_sched_pkg;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } sched_state_e;

endpackage

// File: rtl/rr_pick4.sv
// rr_pick4
//   Purely combinational round-robin picker over four request lines.
//   Ports:
//     req   [3:0] in  : request vector, bit i = channel i requesting
//     start [1:0] in  : channel with highest priority this round
//     grant [1:0] out : first set request at or after start, with wrap
//                       (equals start when nothing is requested)
//     any         out : at least one request is set
module rr_pick4
  import mux_sched_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   start,
  output logic [CH_W-1:0]   grant,
  output logic              any
);

  logic [CH_W-1:0] idx;

  // Walk the offsets from the farthest to the nearest so that the request
  // closest to start is the last one written and therefore wins.
  always_comb begin
    grant = start;
    idx   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx = start + CH_W'(i);
      if (req[idx]) begin
        grant = idx;
      end
    end
    any = |req;
  end

endmodule

// File: rtl/mux4_rr_scheduler.sv
// mux4_rr_scheduler
//   Round-robin select sequencer in front of a structural 4:1 mux. Grants one
//   requesting channel, drives the mux select, waits SETTLE_CYC cycles, samples
//   the mux output and offers it, tagged with its channel, on an output port.
//   Parameters:
//     SETTLE_CYC : cycles between select change and sampling of mux_y (1..15)
//   Ports:
//     clk, rst_n      : clock, asynchronous active-low reset
//     req [3:0]       : per-channel sample request (looked at only in IDLE)
//     mux_y           : output of the downstream 4:1 mux
//     sel [1:0]       : mux select
//     out_valid       : out_data / out_ch hold a sample
//     out_ready       : consumer accepts the sample
//     out_data        : sampled mux_y
//     out_ch [1:0]    : channel the sample came from
//     busy            : FSM not in IDLE
//     state_dbg       : current FSM state, for observation only
//
//   Output handshake: a sample is transferred on a rising edge where
//   out_valid && out_ready. Once out_valid is high, out_valid, out_data and
//   out_ch stay constant until that transfer edge; out_valid never drops
//   without a transfer (except on reset, which drops the sample).
module mux4_rr_scheduler
  import mux_sched_pkg::*;
#(
  parameter int SETTLE_CYC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] req,
  input  logic              mux_y,
  output logic [CH_W-1:0]   sel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_data,
  output logic [CH_W-1:0]   out_ch,
  output logic              busy,
  output sched_state_e      state_dbg
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYC - 1);

  sched_state_e    state;
  logic [CNT_W-1:0] cnt;
  logic [CH_W-1:0]  last_grant;

  logic [CH_W-1:0]  pick_start;
  logic [CH_W-1:0]  pick_grant;
  logic             pick_any;

  // Priority starts just after the last channel that completed a handshake.
  assign pick_start = last_grant + CH_W'(1);

  rr_pick4 u_pick (
    .req   (req),
    .start (pick_start),
    .grant (pick_grant),
    .any   (pick_any)
  );

  // sel/out_ch are only written on the IDLE->SETTLE edge, so the mux select
  // is frozen for the whole settle-and-hold window of a sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= CH_W'(NUM_CH - 1);
      sel        <= '0;
      out_ch     <= '0;
      out_data   <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            sel    <= pick_grant;
            out_ch <= pick_grant;
            cnt    <= CNT_LOAD;
            state  <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt == '0) begin
            out_data  <= mux_y;
            out_valid <= 1'b1;
            state     <= HOLD;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        HOLD: begin
          if (out_valid && out_ready) begin
            out_valid  <= 1'b0;
            last_grant <= out_ch;
            state      <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_mux4_rr_scheduler.sv
module tb_mux4_rr_scheduler;
  import mux_sched_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // DUT with SETTLE_CYC=1
  logic [3:0]   req1, d1;
  logic         ready1, y1, valid1, data1, busy1;
  logic [1:0]   sel1, ch1;
  sched_state_e st1;
  assign y1 = d1[sel1];

  // DUT with SETTLE_CYC=3
  logic [3:0]   req3, d3;
  logic         ready3, y3, valid3, data3, busy3;
  logic [1:0]   sel3, ch3;
  sched_state_e st3;
  assign y3 = d3[sel3];

  int checks   = 0;
  int failures = 0;

  mux4_rr_scheduler #(.SETTLE_CYC(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req(req1), .mux_y(y1), .sel(sel1),
    .out_valid(valid1), .out_ready(ready1), .out_data(data1), .out_ch(ch1),
    .busy(busy1), .state_dbg(st1)
  );

  mux4_rr_scheduler #(.SETTLE_CYC(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req(req3), .mux_y(y3), .sel(sel3),
    .out_valid(valid3), .out_ready(ready3), .out_data(data3), .out_ch(ch3),
    .busy(busy3), .state_dbg(st3)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst_n  = 1'b0;
    req1   = '0; d1 = '0; ready1 = 1'b0;
    req3   = '0; d3 = '0; ready3 = 1'b0;
    @(negedge clk);
    rst_n  = 1'b1;
  endtask

  // Waits up to max negedges for valid1; n = negedges waited.
  task automatic wait_valid1(input int max, output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (n < max && !ok) begin
      @(negedge clk);
      n++;
      if (valid1 === 1'b1) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL wait_valid1: no out_valid within %0d cycles", max);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    req1 = '0; d1 = '0; ready1 = 1'b0;
    req3 = '0; d3 = '0; ready3 = 1'b0;
    #2;
    checks++; if (valid1 !== 1'b0) begin failures++; $display("FAIL reset_valid1: got %b exp 0", valid1); end
    checks++; if (sel1 !== 2'b00) begin failures++; $display("FAIL reset_sel1: got %b exp 00", sel1); end
    checks++; if (ch1 !== 2'b00) begin failures++; $display("FAIL reset_ch1: got %b exp 00", ch1); end
    checks++; if (data1 !== 1'b0) begin failures++; $display("FAIL reset_data1: got %b exp 0", data1); end
    checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL reset_busy1: got %b exp 0", busy1); end
    checks++; if (st1 !== IDLE) begin failures++; $display("FAIL reset_state1: got %0d exp 0", st1); end
    checks++; if (valid3 !== 1'b0) begin failures++; $display("FAIL reset_valid3: got %b exp 0", valid3); end
    checks++; if (busy3 !== 1'b0) begin failures++; $display("FAIL reset_busy3: got %b exp 0", busy3); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_full_rotation();
    logic [1:0] exp_ch [5];
    logic       exp_d  [5];
    int n; bit ok;
    exp_ch = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    exp_d  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    do_reset();
    d1 = 4'b1010; ready1 = 1'b1; req1 = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_valid1(10, n, ok);
      if (ok) begin
        checks++; if (ch1 !== exp_ch[k]) begin failures++; $display("FAIL rot_ch[%0d]: got %0d exp %0d", k, ch1, exp_ch[k]); end
        checks++; if (data1 !== exp_d[k]) begin failures++; $display("FAIL rot_data[%0d]: got %b exp %b", k, data1, exp_d[k]); end
        checks++;
        if (k == 0) begin
          if (n != 2) begin failures++; $display("FAIL rot_latency: got %0d exp 2", n); end
        end else begin
          if (n != 3) begin failures++; $display("FAIL rot_period[%0d]: got %0d exp 3", k, n); end
        end
      end
      if (k == 4) req1 = 4'b0000;
    end
    repeat (3) @(negedge clk);
    checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL rot_idle_busy: got %b exp 0", busy1); end
    checks++; if (valid1 !== 1'b0) begin failures++; $display("FAIL rot_idle_valid: got %b exp 0", valid1); end
  endtask

  task automatic test_sparse_wrap();
    logic [1:0] exp_ch [4];
    logic       exp_d  [4];
    int n; bit ok;
    exp_ch = '{2'd0, 2'd3, 2'd0, 2'd3};
    exp_d  = '{1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    d1 = 4'b1010; ready1 = 1'b1; req1 = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      wait_valid1(10, n, ok);
      if (ok) begin
        checks++; if (ch1 !== exp_ch[k]) begin failures++; $display("FAIL sparse_ch[%0d]: got %0d exp %0d", k, ch1, exp_ch[k]); end
        checks++; if (data1 !== exp_d[k]) begin failures++; $display("FAIL sparse_data[%0d]: got %b exp %b", k, data1, exp_d[k]); end
      end
      if (k == 3) req1 = 4'b0000;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_backpressure();
    int n; bit ok;
    do_reset();
    d1 = 4'b0100; ready1 = 1'b0; req1 = 4'b0100;
    wait_valid1(10, n, ok);
    req1 = 4'b0000;
    d1   = 4'b0000;   // mux input moves; the held sample must not
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (valid1 !== 1'b1) begin failures++; $display("FAIL bp_valid[%0d]: got %b exp 1", i, valid1); end
      checks++; if (data1 !== 1'b1) begin failures++; $display("FAIL bp_data[%0d]: got %b exp 1", i, data1); end
      checks++; if (ch1 !== 2'd2) begin failures++; $display("FAIL bp_ch[%0d]: got %0d exp 2", i, ch1); end
      checks++; if (sel1 !== 2'd2) begin failures++; $display("FAIL bp_sel[%0d]: got %0d exp 2", i, sel1); end
    end
    ready1 = 1'b1;
    @(negedge clk);
    checks++; if (valid1 !== 1'b0) begin failures++; $display("FAIL bp_release_valid: got %b exp 0", valid1); end
    checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL bp_release_busy: got %b exp 0", busy1); end
    ready1 = 1'b0;
  endtask

  task automatic test_settle_timing();
    do_reset();
    d3 = 4'b0000; ready3 = 1'b0; req3 = 4'b0100;
    @(negedge clk);   // after grant edge
    checks++; if (sel3 !== 2'b10) begin failures++; $display("FAIL settle_sel: got %b exp 10", sel3); end
    checks++; if (busy3 !== 1'b1) begin failures++; $display("FAIL settle_busy: got %b exp 1", busy3); end
    checks++; if (valid3 !== 1'b0) begin failures++; $display("FAIL settle_valid_e1: got %b exp 0", valid3); end
    req3 = 4'b0000;
    @(negedge clk);   // after grant+1
    checks++; if (valid3 !== 1'b0) begin failures++; $display("FAIL settle_valid_e2: got %b exp 0", valid3); end
    @(negedge clk);   // after grant+2
    checks++; if (valid3 !== 1'b0) begin failures++; $display("FAIL settle_valid_e3: got %b exp 0", valid3); end
    d3 = 4'b0100;     // only the third edge sees input 2 high
    @(negedge clk);   // after grant+3
    checks++; if (valid3 !== 1'b1) begin failures++; $display("FAIL settle_valid_e4: got %b exp 1", valid3); end
    checks++; if (data3 !== 1'b1) begin failures++; $display("FAIL settle_data: got %b exp 1", data3); end
    checks++; if (ch3 !== 2'd2) begin failures++; $display("FAIL settle_ch: got %0d exp 2", ch3); end
    ready3 = 1'b1;
    @(negedge clk);
    checks++; if (valid3 !== 1'b0) begin failures++; $display("FAIL settle_done_valid: got %b exp 0", valid3); end
    checks++; if (busy3 !== 1'b0) begin failures++; $display("FAIL settle_done_busy: got %b exp 0", busy3); end
    ready3 = 1'b0;
  endtask

  task automatic test_request_drop();
    do_reset();
    d1 = 4'b0010; ready1 = 1'b1; req1 = 4'b0010;
    @(negedge clk);
    checks++; if (sel1 !== 2'd1) begin failures++; $display("FAIL drop_sel: got %0d exp 1", sel1); end
    checks++; if (busy1 !== 1'b1) begin failures++; $display("FAIL drop_busy_settle: got %b exp 1", busy1); end
    req1 = 4'b0000;
    @(negedge clk);
    checks++; if (valid1 !== 1'b1) begin failures++; $display("FAIL drop_valid: got %b exp 1", valid1); end
    checks++; if (ch1 !== 2'd1) begin failures++; $display("FAIL drop_ch: got %0d exp 1", ch1); end
    checks++; if (data1 !== 1'b1) begin failures++; $display("FAIL drop_data: got %b exp 1", data1); end
    @(negedge clk);
    checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL drop_idle_busy: got %b exp 0", busy1); end
    @(negedge clk);
    checks++; if (st1 !== IDLE) begin failures++; $display("FAIL drop_idle_state: got %0d exp 0", st1); end
    checks++; if (valid1 !== 1'b0) begin failures++; $display("FAIL drop_idle_valid: got %b exp 0", valid1); end
  endtask

  task automatic test_reset_mid_hold();
    int n; bit ok;
    do_reset();
    d1 = 4'b1111; ready1 = 1'b1; req1 = 4'b0100;
    wait_valid1(10, n, ok);
    checks++; if (ch1 !== 2'd2) begin failures++; $display("FAIL rmh_first_ch: got %0d exp 2", ch1); end
    req1 = 4'b1000;
    @(negedge clk);   // channel 2 handshake done, last grant now 2
    ready1 = 1'b0;
    wait_valid1(10, n, ok);
    checks++; if (ch1 !== 2'd3) begin failures++; $display("FAIL rmh_hold_ch: got %0d exp 3", ch1); end
    #2 rst_n = 1'b0;  // mid-cycle, no clock edge before the checks
    #1;
    checks++; if (valid1 !== 1'b0) begin failures++; $display("FAIL rmh_valid: got %b exp 0", valid1); end
    checks++; if (sel1 !== 2'b00) begin failures++; $display("FAIL rmh_sel: got %b exp 00", sel1); end
    checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL rmh_busy: got %b exp 0", busy1); end
    checks++; if (ch1 !== 2'b00) begin failures++; $display("FAIL rmh_ch: got %b exp 00", ch1); end
    @(negedge clk);
    rst_n = 1'b1; ready1 = 1'b1; req1 = 4'b1110;
    wait_valid1(10, n, ok);
    checks++; if (ch1 !== 2'd1) begin failures++; $display("FAIL rmh_after_ch: got %0d exp 1", ch1); end
    req1 = 4'b0000;
    repeat (2) @(negedge clk);
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_full_rotation();
    test_sparse_wrap();
    test_backpressure();
    test_settle_timing();
    test_request_drop();
    test_reset_mid_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
